// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Single-issue ALU execution unit. Non-shift operations complete in one
//   cycle; shifts by N>0 are performed serially, one bit per cycle, in a
//   working register, so the result appears N+1 cycles after acceptance.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. Once out_valid is raised, result/zero/illegal hold
//   stable until the edge where out_ready is high. in_ready never depends on
//   in_valid, and out_valid never depends on out_ready.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset (wins over flush and in_valid)
//   flush      : synchronous abort of the operation in flight
//   in_valid   : request valid          in_ready  : unit can accept
//   alu_ctrl   : operation code         op_a/op_b : source operands
//   out_valid  : result valid           out_ready : consumer accepts result
//   result     : operation result       zero      : result == 0
//   illegal    : alu_ctrl was unsupported
//   dbg_state  : current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Serial shift direction held while in SHIFT.
  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_kind;

  logic            w_accept;
  logic [XLEN-1:0] w_res;
  logic            w_ill;
  logic            w_is_shift;
  logic [1:0]      w_kind;
  logic [SHW-1:0]  w_shamt;

  // in_ready is combinational on out_ready so a finished result can be
  // consumed and a new request accepted on the same edge (no bubble).
  assign in_ready  = rst_n && !flush &&
                     ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = op_b[SHW-1:0];

  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign zero      = (r_result == '0);
  assign dbg_state = r_state;

  // Single-cycle operations. For shifts the value here is op_a, which is the
  // correct result for a zero shift amount and the start value otherwise.
  always_comb begin
    w_res      = '0;
    w_ill      = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = K_SLL;
    case (alu_ctrl)
      4'd0: w_res = op_a + op_b;
      4'd1: w_res = op_a - op_b;
      4'd2: w_res = op_a & op_b;
      4'd3: w_res = op_a | op_b;
      4'd4: w_res = op_a ^ op_b;
      4'd5: w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd6: begin w_res = op_a; w_is_shift = 1'b1; w_kind = K_SLL; end
      4'd7: begin w_res = op_a; w_is_shift = 1'b1; w_kind = K_SRL; end
      4'd8: begin w_res = op_a; w_is_shift = 1'b1; w_kind = K_SRA; end
      4'd9: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: begin w_res = '0; w_ill = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_kind    <= K_SLL;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_result  <= w_res;
            r_illegal <= w_ill;
            r_kind    <= w_kind;
            if (w_is_shift && (w_shamt != '0)) begin
              r_state <= S_SHIFT;
              r_cnt   <= w_shamt;
            end else begin
              r_state <= S_DONE;
              r_cnt   <= '0;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          case (r_kind)
            K_SLL:   r_result <= {r_result[XLEN-2:0], 1'b0};
            K_SRL:   r_result <= {1'b0, r_result[XLEN-1:1]};
            default: r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
          endcase
          r_cnt <= r_cnt - CNT_ONE;
          // The last shift happens on the edge where the count goes 1 -> 0.
          if (r_cnt == CNT_ONE) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Scoreboard bench for alu_exec_unit (XLEN = 32). Drivers push the expected
//   response of every accepted request into exp_q; an independent monitor
//   compares whatever the unit presents against the queue head.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic [1:0]   dbg_state;

  alu_exec_unit #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           due;   // cyc value in which out_valid must first be seen
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain operator semantics, shift latency = amount.
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic ill, output int lat);
    int sh;
    sh  = int'(b % W);
    ill = 1'b0;
    lat = 0;
    case (c)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6: begin res = a << sh; lat = sh; end
      4'd7: begin res = a >> sh; lat = sh; end
      4'd8: begin res = $signed(a) >>> sh; lat = sh; end
      4'd9: res = (a < b) ? 1 : 0;
      default: begin res = '0; ill = 1'b1; end
    endcase
  endtask

  // ---------------- monitor ----------------
  logic held = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, '0);
      end else begin
        if (!held) check("latency", W'(cyc), W'(exp_q[0].due));
        check("result",  result, exp_q[0].res);
        check("zero",    {31'b0, zero}, {31'b0, (exp_q[0].res == '0)});
        check("illegal", {31'b0, illegal}, {31'b0, exp_q[0].ill});
        if (rst_n) check("in_ready_done", {31'b0, in_ready}, {31'b0, out_ready && !flush});
        if (out_ready && !flush) begin
          void'(exp_q.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  bit rand_ordy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int   waited = 0;
    exp_t e;
    int   lat;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model(c, a, b, e.res, e.ill, lat);
        e.due = cyc + 1 + lat;
        exp_q.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Post-acceptance operand changes must not affect the result.
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  '0);
    check("rst_out_valid", {31'b0, out_valid}, '0);
    check("rst_result",    result, '0);
    check("rst_zero",      {31'b0, zero},    32'd1);
    check("rst_illegal",   {31'b0, illegal}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // SUB 5-5 -> zero, latency 1
    out_ready = 1'b1;
    issue(4'd1, 32'd5, 32'd5);
    // SLT / SLTU signedness
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    drain();

    // SRA by 4 (upper op_b bits ignored): 4 busy cycles, then result
    @(posedge clk); #1;
    issue(4'd8, 32'h8000_0000, 32'h24);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sra_busy_in_ready",  {31'b0, in_ready},  '0);
      check("sra_busy_out_valid", {31'b0, out_valid}, '0);
    end
    @(negedge clk);
    check("sra_out_valid", {31'b0, out_valid}, 32'd1);
    check("sra_result", result, 32'hF800_0000);
    drain();

    // Backpressure for 3 cycles, then consume + accept on the same edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd4, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  {31'b0, in_ready},  '0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd0, 32'd1, 32'd2);
    @(negedge clk);
    check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_result", result, 32'd3);
    drain();

    // Flush in 2nd cycle of SLL by 10
    @(posedge clk); #1;
    issue(4'd6, 32'h0000_0001, 32'd10);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", {31'b0, in_ready}, '0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid}, '0);
    check("flush_in_ready",  {31'b0, in_ready},  32'd1);
    repeat (15) @(posedge clk);
    #1;

    // Illegal opcode, latency 1
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    drain();

    // Reset in the middle of SRL by 20
    @(posedge clk); #1;
    issue(4'd7, 32'hFFFF_FFFF, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, '0);
    check("mid_rst_result",    result, '0);
    check("mid_rst_zero",      {31'b0, zero},     32'd1);
    check("mid_rst_illegal",   {31'b0, illegal},  '0);
    check("mid_rst_in_ready",  {31'b0, in_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    // Randomized stream with random backpressure
    rand_ordy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [3:0]   c;
      logic [W-1:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = a;
        2: b = b & 32'hFFFF_FFE0;   // shift amount 0
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(c, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();
    rand_ordy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit; synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid, input, 1 bit; the operation request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit; the unit can accept a request.
REQ-007 SHALL have port alu_ctrl, input, 4 bits; the operation code from the ALU control decoder.
REQ-008 SHALL have ports op_a and op_b, input, XLEN bits each; the source operands.
REQ-009 SHALL have port out_valid, output, 1 bit; result, zero and illegal are valid.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN bits; the operation result.
REQ-012 SHALL have port zero, output, 1 bit; high when result equals 0, for branch resolution.
REQ-013 SHALL have port illegal, output, 1 bit; high when alu_ctrl was unsupported.

Function
REQ-014 SHALL decode alu_ctrl as follows: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
REQ-015 SHALL treat codes 1010-1111 as illegal: result 0, zero 1, illegal 1, with the same latency as ADD.
REQ-016 SHALL compute ADD/SUB modulo 2^XLEN, discarding the carry out.
REQ-017 SHALL return a result of 1 or 0 zero-extended to XLEN for SLT and SLTU.
REQ-018 SHALL take the shift amount as op_b[log2(XLEN)-1:0] and ignore all upper bits of op_b.
REQ-019 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-020 SHALL hold in_ready high in IDLE, and also in DONE in any cycle where out_ready is high; in_ready SHALL be low in SHIFT and whenever flush is high.
REQ-021 SHALL accept a request on a clock edge where in_valid, in_ready and not-flush are all high, capturing alu_ctrl, op_a and op_b.
REQ-022 SHALL, on accepting a non-shift request or a shift with amount 0, register the result and enter DONE, so that out_valid is high the next cycle (latency 1).
REQ-023 SHALL, on accepting a shift with amount N>0, enter SHIFT with count N and shift the working register by one bit per cycle (SRA replicating the sign bit), decrementing the count each cycle.
REQ-024 SHALL move from SHIFT to DONE when the count reaches 0, so that the total latency is N+1 cycles and out_valid rises N+1 cycles after the accepting edge.
REQ-025 SHALL keep out_valid high only in DONE, holding result, zero and illegal stable until out_ready is sampled high.
REQ-026 SHALL, in DONE with out_ready high: if a new request is also accepted, handle it per REQ-022/023 (back-to-back, with no bubble); otherwise return to IDLE.
REQ-027 SHALL, when flush is high, go to IDLE on the next edge from any state, drop out_valid, discard the in-flight result, and accept no request in that cycle.
REQ-028 SHALL derive zero combinationally from the registered result.
REQ-029 SHALL ignore operand and alu_ctrl changes made after acceptance.

Reset
REQ-030 SHALL, while rst_n is low at a clock edge, enter IDLE and set out_valid=0, result=0, zero=1, illegal=0 and shift count=0.
REQ-031 SHALL have rst_n take priority over flush and over in_valid; a reset mid-SHIFT SHALL abort the operation with no out_valid pulse.
REQ-032 SHALL hold in_ready low while rst_n is low.

Verification
REQ-033 SHALL cover: SUB with op_a=5, op_b=5, out_ready=1 -> out_valid 1 cycle after accept, result 0, zero 1.
REQ-034 SHALL cover: SLT with op_a=0xFFFFFFFF, op_b=1 -> result 1; SLTU with the same operands -> result 0.
REQ-035 SHALL cover: SRA with op_a=0x80000000, op_b=0x24 (amount 4) -> in_ready low for 4 cycles, out_valid at accept+5, result 0xF8000000.
REQ-036 SHALL cover: out_ready held low for 3 cycles in DONE -> result stable and in_ready low; then out_ready=1 together with in_valid=1 (ADD 1+2) -> new request accepted the same edge and result 3 on the next cycle.
REQ-037 SHALL cover: flush asserted during the 2nd cycle of SLL by 10 -> IDLE next cycle, no out_valid pulse, in_ready high.
REQ-038 SHALL cover: alu_ctrl=1111 -> illegal 1, result 0, latency 1; and rst_n low mid-SHIFT -> all outputs at reset values on the next cycle.
